// File: rtl/ddr_lane_engine.sv
// ddr_lane_engine: DDR playfield core. Scrolls an arrow chart down LANES
// columns on each beat, scans the LED matrix one lane at a time, judges pad
// presses against the bottom (target) row and keeps saturating hit/miss tallies.
module ddr_lane_engine #(
  parameter int LANES     = 4,
  parameter int ROWS      = 8,
  parameter int SCAN_BITS = 16,
  parameter int SCORE_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bpmClk,
  input  logic [LANES-1:0]   step,
  input  logic [LANES-1:0]   pad,
  output logic [LANES-1:0]   colEnOut,
  output logic [ROWS-1:0]    col,
  output logic [SCORE_W-1:0] hitCount,
  output logic [SCORE_W-1:0] missCount,
  output logic               hitPulse,
  output logic               missPulse
);

  // Lane selector width; LANES need not be a power of two.
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  // Width able to hold a per-cycle popcount of LANES bits.
  localparam int CNT_W = $clog2(LANES + 1);

  // Score additions are done one bit wider than the wider operand so the
  // carry is visible before clamping.
  localparam int SUM_W = ((SCORE_W > CNT_W) ? SCORE_W : CNT_W) + 1;
  localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'({SCORE_W{1'b1}});

  // Registered state
  logic                 bpm_q;
  logic [LANES-1:0]     pad_q;
  logic [ROWS-1:0]      chart [LANES];
  logic [SCAN_BITS-1:0] scan_cnt;
  logic [LANE_W-1:0]    lane_sel;
  logic [SCORE_W-1:0]   hit_cnt;
  logic [SCORE_W-1:0]   miss_cnt;
  logic                 hit_pulse;
  logic                 miss_pulse;

  // Combinational judge / scroll results
  logic                 beat;
  logic [LANES-1:0]     press;
  logic [LANES-1:0]     hit;
  logic [LANES-1:0]     miss;
  logic [ROWS-1:0]      chart_next [LANES];
  logic [SCORE_W-1:0]   hit_cnt_next;
  logic [SCORE_W-1:0]   miss_cnt_next;

  // Count set bits in a lane vector.
  function automatic logic [CNT_W-1:0] popcount(input logic [LANES-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < LANES; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  // Add a popcount to a score and clamp at the largest representable score.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] cur,
                                                 input logic [CNT_W-1:0]   add);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(cur) + SUM_W'(add);
    if (sum > SCORE_MAX) begin
      return {SCORE_W{1'b1}};
    end
    return sum[SCORE_W-1:0];
  endfunction

  // Edge detection, hit/miss judging and next chart contents for every lane.
  // A press is judged against the target bit as it stands before any scroll,
  // so a same-cycle press and beat can hit and then suppresses the miss.
  always_comb begin
    beat  = bpmClk & ~bpm_q;
    press = pad & ~pad_q;
    hit   = '0;
    miss  = '0;
    for (int l = 0; l < LANES; l++) begin
      chart_next[l] = chart[l];
      hit[l]  = press[l] & chart[l][ROWS-1];
      miss[l] = beat & chart[l][ROWS-1] & ~hit[l];
      if (hit[l]) begin
        chart_next[l][ROWS-1] = 1'b0;
      end
      if (beat) begin
        chart_next[l] = {chart[l][ROWS-2:0], step[l]};
      end
    end
  end

  // Next values of the saturating tallies.
  always_comb begin
    hit_cnt_next  = sat_add(hit_cnt, popcount(hit));
    miss_cnt_next = sat_add(miss_cnt, popcount(miss));
  end

  // Previous-cycle copies of beat and pad levels; reset to ones so a level
  // already high when reset releases does not look like a fresh edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bpm_q <= 1'b1;
      pad_q <= '1;
    end else begin
      bpm_q <= bpmClk;
      pad_q <= pad;
    end
  end

  // Scan divider: lane_sel moves on to the next lane each time the free
  // running counter wraps.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_cnt <= '0;
      lane_sel <= '0;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      if (&scan_cnt) begin
        if (lane_sel == LAST_LANE) begin
          lane_sel <= '0;
        end else begin
          lane_sel <= lane_sel + 1'b1;
        end
      end
    end
  end

  // Chart storage: scroll on beat, clear the target bit on a hit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int l = 0; l < LANES; l++) begin
        chart[l] <= '0;
      end
    end else begin
      for (int l = 0; l < LANES; l++) begin
        chart[l] <= chart_next[l];
      end
    end
  end

  // Score tallies and their one-cycle indication pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      hit_cnt    <= hit_cnt_next;
      miss_cnt   <= miss_cnt_next;
      hit_pulse  <= |hit;
      miss_pulse <= |miss;
    end
  end

  // LED matrix drive: active-low enable for the scanned lane and its chart bits.
  always_comb begin
    colEnOut = ~(LANES'(1) << lane_sel);
    col      = chart[lane_sel];
  end

  assign hitCount  = hit_cnt;
  assign missCount = miss_cnt;
  assign hitPulse  = hit_pulse;
  assign missPulse = miss_pulse;

endmodule
